scan_chain_controller: RTL and testbench

SCAN_CHAIN_CONTROLLER -- requirements
Module: scan_chain_controller

---
 rtl/scan_chain_controller.sv | 138 +++++++++++++
 tb/tb_scan_chain_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_controller.sv
// Scan-chain controller: holds a CHAIN_LEN-bit image, swaps it with a
// microcontroller scan chain (SHIFT) or lets the core run for a bounded budget (RUN).
module scan_chain_controller #(
  parameter int CHAIN_LEN = 152,
  parameter int NBYTES    = CHAIN_LEN / 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       img_we,
  input  logic [4:0] img_addr,
  input  logic [7:0] img_wdata,
  output logic [7:0] img_rdata,
  input  logic       cmd_valid,
  input  logic       cmd_op,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       halted,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       proc_en,
  input  logic       halt
);

  localparam int CLEN_W = $clog2(CHAIN_LEN + 1);
  localparam int CNT_W  = (CLEN_W > 8) ? CLEN_W : 8;
  localparam logic [5:0] NBYTES_W = 6'(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_RUN
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CHAIN_LEN-1:0] image;
  logic [CNT_W-1:0]     cnt;
  logic                 accept;
  logic                 finish;
  logic                 addr_ok;
  logic                 last_cnt;
  logic [7:0]           byte_base;

  assign accept    = cmd_valid && (state == S_IDLE);
  assign addr_ok   = {1'b0, img_addr} < NBYTES_W;
  assign last_cnt  = (cnt == CNT_W'(1));
  assign byte_base = {img_addr, 3'b000};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!cmd_op) begin
            state_next = S_SHIFT;
          end else if (cmd_arg != 8'd0) begin
            state_next = S_RUN;
          end else begin
            finish = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (last_cnt) begin
          state_next = S_IDLE;
          finish     = 1'b1;
        end
      end
      S_RUN: begin
        // Halt wins over budget exhaustion when both land in the same cycle.
        if (halt || last_cnt) begin
          state_next = S_IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cmd_op ? CNT_W'(cmd_arg) : CNT_W'(CHAIN_LEN);
    end else if (finish) begin
      cnt <= '0;
    end else if (state != S_IDLE) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      halted <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        halted <= 1'b0;
      end else if ((state == S_RUN) && halt) begin
        halted <= 1'b1;
      end
    end
  end

  // NOTE: the image is a flop vector, not a RAM, so it is cleared on reset like any register.
  always_ff @(posedge clk) begin
    if (rst) begin
      image <= '0;
    end else if (state == S_SHIFT) begin
      image <= {image[CHAIN_LEN-2:0], scan_out};
    end else if ((state == S_IDLE) && img_we && addr_ok) begin
      image[byte_base +: 8] <= img_wdata;
    end
  end

  assign img_rdata   = addr_ok ? image[byte_base +: 8] : 8'h00;
  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign scan_enable = (state == S_SHIFT);
  assign proc_en     = (state == S_RUN);
  assign scan_in     = scan_enable & image[CHAIN_LEN-1];

endmodule

// File: tb/tb_scan_chain_controller.sv
// Randomized bench for scan_chain_controller: a byte-level image/chain swap model
// plus closed-form RUN expectations (min of budget and halt cycle).
module tb_scan_chain_controller;

  localparam int L  = 152;
  localparam int NB = L / 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       img_we;
  logic [4:0] img_addr;
  logic [7:0] img_wdata;
  logic [7:0] img_rdata;
  logic       cmd_valid;
  logic       cmd_op;
  logic [7:0] cmd_arg;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic       halted;
  logic       scan_enable;
  logic       scan_in;
  logic       scan_out;
  logic       proc_en;
  logic       halt;

  scan_chain_controller #(.CHAIN_LEN(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .img_we     (img_we),
    .img_addr   (img_addr),
    .img_wdata  (img_wdata),
    .img_rdata  (img_rdata),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .cmd_ready  (cmd_ready),
    .busy       (busy),
    .done       (done),
    .halted     (halted),
    .scan_enable(scan_enable),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .proc_en    (proc_en),
    .halt       (halt)
  );

  always #5 clk = ~clk;

  // Stand-in for the microcontroller's scan chain.
  logic [L-1:0] chain;
  logic         chain_ld;
  logic [L-1:0] chain_ld_val;

  always @(posedge clk) begin
    if (chain_ld) chain <= chain_ld_val;
    else if (scan_enable) chain <= {chain[L-2:0], scan_in};
  end
  assign scan_out = chain[L-1];

  logic [7:0] exp_img[NB];
  logic [7:0] exp_chain[NB];

  int n_cmp = 0;
  int n_bad = 0;

  // Per-command observations.
  int se_cnt, pe_cnt, done_cnt, done_at, viol;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_byte(input logic [4:0] addr, input logic [7:0] data);
    @(negedge clk);
    img_we = 1'b1; img_addr = addr; img_wdata = data;
    @(negedge clk);
    img_we = 1'b0;
    if (int'(addr) < NB) exp_img[addr] = data;
  endtask

  task automatic load_chain();
    for (int k = 0; k < NB; k++) begin
      exp_chain[k] = 8'($urandom);
      chain_ld_val[8*k +: 8] = exp_chain[k];
    end
    @(negedge clk);
    chain_ld = 1'b1;
    @(negedge clk);
    chain_ld = 1'b0;
  endtask

  // Issue one command; optionally raise halt / rst / a stray write at cycle n (1 = first cycle after accept).
  task automatic issue(input logic op, input logic [7:0] arg, input int halt_at,
                       input int rst_at, input int wr_at);
    int n;
    int stop_n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; halt = 1'b0;
    se_cnt = 0; pe_cnt = 0; done_cnt = 0; done_at = 0; viol = 0;
    n = 0;
    stop_n = L + 300;
    while (n < stop_n) begin
      @(negedge clk);
      n++;
      cmd_valid = 1'b0;
      if (scan_enable) se_cnt++;
      if (proc_en) pe_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = n;
          stop_n  = n + 3;
        end
      end
      if (scan_enable && proc_en) viol++;
      if (!scan_enable && scan_in) viol++;
      if (busy === cmd_ready) viol++;
      if (n == halt_at) halt = 1'b1;
      rst = (n == rst_at);
      if (rst_at > 0 && n == rst_at + 5) stop_n = n;
      if (n == wr_at) begin
        img_we = 1'b1; img_addr = 5'($urandom_range(0, NB - 1)); img_wdata = 8'($urandom);
      end else begin
        img_we = 1'b0;
      end
    end
    halt = 1'b0; rst = 1'b0; img_we = 1'b0;
  endtask

  task automatic post(input string tag, input int e_se, input int e_pe, input int e_done_at,
                      input int e_done_cnt, input logic e_halted);
    check({tag, " scan_en cycles"}, se_cnt, e_se);
    check({tag, " proc_en cycles"}, pe_cnt, e_pe);
    check({tag, " done cycle"}, done_at, e_done_at);
    check({tag, " done count"}, done_cnt, e_done_cnt);
    check({tag, " protocol"}, viol, 0);
    check({tag, " halted"}, halted, e_halted);
    check({tag, " cmd_ready"}, cmd_ready, 1'b1);
  endtask

  task automatic readback(input string tag, input bit with_chain);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      img_addr = 5'(k);
      #1;
      check($sformatf("%s img[%0d]", tag, k), img_rdata, exp_img[k]);
      if (with_chain) check($sformatf("%s chain[%0d]", tag, k), chain[8*k +: 8], exp_chain[k]);
    end
    @(negedge clk);
    img_addr = 5'(NB);
    #1;
    check({tag, " rdata out of range"}, img_rdata, 8'h00);
    img_addr = 5'd31;
    #1;
    check({tag, " rdata addr 31"}, img_rdata, 8'h00);
  endtask

  task automatic do_shift(input string tag, input int wr_at);
    logic [7:0] t;
    issue(1'b0, 8'd0, 0, 0, wr_at);
    post(tag, L, 0, L + 1, 1, 1'b0);
    for (int k = 0; k < NB; k++) begin
      t = exp_img[k]; exp_img[k] = exp_chain[k]; exp_chain[k] = t;
    end
    readback(tag, 1'b1);
  endtask

  task automatic do_run(input string tag, input logic [7:0] arg, input int halt_at);
    int  e_pe;
    bit  e_h;
    e_h  = (arg != 0) && (halt_at > 0) && (halt_at <= int'(arg));
    e_pe = e_h ? halt_at : int'(arg);
    issue(1'b1, arg, halt_at, 0, 0);
    post(tag, 0, e_pe, e_pe + 1, 1, e_h);
  endtask

  localparam logic [63:0] PROG = 64'hE4E3E2E1E001E009;

  initial begin
    logic [63:0] prog;
    rst = 1'b1; img_we = 1'b0; img_addr = '0; img_wdata = '0;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_arg = '0; halt = 1'b0;
    chain_ld = 1'b0; chain_ld_val = '0;
    for (int k = 0; k < NB; k++) exp_img[k] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset cmd_ready", cmd_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset halted", halted, 1'b0);
    check("reset scan_enable", scan_enable, 1'b0);
    check("reset proc_en", proc_en, 1'b0);
    check("reset scan_in", scan_in, 1'b0);
    load_chain();
    readback("reset", 1'b0);

    // Directed program image, then swap into the chain.
    prog = PROG;
    for (int k = 0; k < 8; k++) write_byte(5'(k), prog[8*k +: 8]);
    for (int k = 8; k < NB; k++) write_byte(5'(k), 8'($urandom));
    do_shift("shift1", 0);
    do_run("run8", 8'd8, 0);
    for (int k = 0; k < NB; k++) write_byte(5'(k), 8'h00);
    do_shift("shift2", 0);
    do_run("run20 halt3", 8'd20, 3);
    do_run("run5 clears halted", 8'd5, 0);
    do_run("run halt at budget", 8'd4, 4);

    // Randomized mix of writes (including out-of-range), SHIFTs and RUNs.
    for (int it = 0; it < 8; it++) begin
      repeat (3) write_byte(5'($urandom_range(0, 31)), 8'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        do_shift($sformatf("rnd%0d shift", it), 0);
      end else begin
        do_run($sformatf("rnd%0d run", it), 8'($urandom_range(0, 25)),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 30)) : 0);
      end
    end

    // Reset in SHIFT cycle 50 aborts without done and clears the image.
    issue(1'b0, 8'd0, 0, 50, 0);
    post("rst mid-shift", 50, 0, 0, 0, 1'b0);
    for (int k = 0; k < NB; k++) exp_img[k] = 8'h00;
    readback("after rst", 1'b0);
    load_chain();

    // Writes while busy and out-of-range writes are ignored; RUN 0 is an immediate done.
    for (int k = 0; k < NB; k++) write_byte(5'(k), 8'($urandom));
    do_shift("shift with busy write", 40);
    write_byte(5'd19, 8'hA5);
    do_run("run0", 8'd0, 0);
    readback("final", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
